// File: rtl/dc_pkg.sv
// -----------------------------------------------------------------------------
// dc_pkg
// Shared definitions for the device data collector.
//   dc_state_e  : bus-issue FSM states (IDLE -> ISSUE -> GAP -> IDLE)
//   GRANT_*     : encoding of the last bus owner, used for fair alternation
//   OVERRUN_MAX : saturation value of the dropped-trigger counter
//   sat_inc8    : saturating 8-bit increment
// -----------------------------------------------------------------------------
package dc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } dc_state_e;

  localparam logic GRANT_SNAP = 1'b0;
  localparam logic GRANT_RX   = 1'b1;

  localparam logic [7:0] OVERRUN_MAX = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == OVERRUN_MAX) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/device_data_collector_n_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Two-flop synchroniser for an asynchronous level (e.g. a 1PPS input) followed
// by a rising-edge detector. PULSE is high for one CLK cycle, two edges after
// the input rises, so a consumer registering on PULSE acts on the third edge.
// Ports:
//   CLK      in  system clock
//   RESET_N  in  synchronous active-low reset
//   ASYNC_IN in  asynchronous level input
//   PULSE    out one-cycle rising-edge pulse (decoded from registers only)
// -----------------------------------------------------------------------------
module sync_edge_detect
  import dc_pkg::*;
(
  input  logic CLK,
  input  logic RESET_N,
  input  logic ASYNC_IN,
  output logic PULSE
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchroniser chain plus one delayed copy for edge detection
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= ASYNC_IN;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign PULSE = sync2_r & ~prev_r;

endmodule

// File: rtl/device_data_collector_n.sv
// -----------------------------------------------------------------------------
// device_data_collector_n
// On each synchronised 1PPS rising edge, snapshots NUM_REGS status words into a
// shadow bank and serialises the masked ones as register writes at
// ADDR_BASE+i. Shares the write bus with a single-entry receiver channel.
// Ports:
//   CLK, RESET_N            clock, synchronous active-low reset
//   SNAP_TRIG               asynchronous 1PPS trigger
//   SNAP_DATA / SNAP_MASK   flat status words / per-word emit enable
//   Reveiver_*              receiver write channel in, holding-buffer busy out
//   TR_IN/ADDR_IN/DATA_IN   write strobe, address, data to register file
//   TR_IN_BUSY              downstream back-pressure
//   SNAP_BUSY/SNAP_DONE     dump in progress / one-cycle end-of-dump pulse
//   OVERRUN_CNT             saturating count of triggers dropped mid-dump
// -----------------------------------------------------------------------------
module device_data_collector_n
  import dc_pkg::*;
#(
  parameter int                NUM_REGS  = 21,
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] ADDR_BASE = 16'd300
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       SNAP_TRIG,
  input  logic [NUM_REGS*DATA_W-1:0] SNAP_DATA,
  input  logic [NUM_REGS-1:0]        SNAP_MASK,
  input  logic                       Reveiver_priority,
  input  logic [ADDR_W-1:0]          Reveiver_ADDR,
  input  logic [DATA_W-1:0]          Reveiver_DATA,
  input  logic                       Reveiver_TR,
  output logic                       Reveiver_TR_IN_BUSY,
  output logic                       TR_IN,
  output logic [ADDR_W-1:0]          ADDR_IN,
  output logic [DATA_W-1:0]          DATA_IN,
  input  logic                       TR_IN_BUSY,
  output logic                       SNAP_BUSY,
  output logic                       SNAP_DONE,
  output logic [7:0]                 OVERRUN_CNT
);

  localparam int               IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  dc_state_e           state_r;
  dc_state_e           state_nxt_s;

  logic                trig_pulse_s;
  logic [DATA_W-1:0]   shadow_r [NUM_REGS];
  logic [NUM_REGS-1:0] mask_r;
  logic [IDX_W-1:0]    idx_r;
  logic                snap_busy_r;
  logic                snap_done_r;
  logic [7:0]          overrun_r;
  logic                last_grant_r;

  logic                rx_full_r;
  logic                rx_prio_r;
  logic [ADDR_W-1:0]   rx_addr_r;
  logic [DATA_W-1:0]   rx_data_r;

  logic                tr_in_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   data_r;

  logic                rx_win_s;
  logic                grant_rx_s;
  logic                grant_snap_s;
  logic                skip_s;
  logic                consume_s;
  logic                last_consume_s;
  logic                capture_s;
  logic                drop_s;
  logic                rx_accept_s;
  logic                rx_release_s;

  sync_edge_detect u_trig_sync (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .ASYNC_IN (SNAP_TRIG),
    .PULSE    (trig_pulse_s)
  );

  // Receiver wins when it holds an entry and either has priority, the
  // snapshot had the bus last (fair alternation) or no dump is running.
  assign rx_win_s = rx_full_r &
                    (rx_prio_r | (last_grant_r == GRANT_SNAP) | ~snap_busy_r);

  // Next-state and grant decode; grants/skips only happen in IDLE with the
  // downstream ready.
  always_comb begin
    state_nxt_s  = state_r;
    grant_rx_s   = 1'b0;
    grant_snap_s = 1'b0;
    skip_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!TR_IN_BUSY) begin
          if (rx_win_s) begin
            grant_rx_s  = 1'b1;
            state_nxt_s = ST_ISSUE;
          end else if (snap_busy_r && mask_r[idx_r]) begin
            grant_snap_s = 1'b1;
            state_nxt_s  = ST_ISSUE;
          end else if (snap_busy_r) begin
            skip_s      = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_GAP;
      ST_GAP:   state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  assign consume_s      = grant_snap_s | skip_s;
  assign last_consume_s = consume_s & (idx_r == LAST_IDX);
  // Finishing the last word frees the bank in the same cycle, so a
  // coincident trigger is a fresh capture rather than an overrun.
  assign capture_s      = trig_pulse_s & (~snap_busy_r | last_consume_s);
  assign drop_s         = trig_pulse_s & snap_busy_r & ~last_consume_s;
  assign rx_accept_s    = Reveiver_TR & ~rx_full_r;
  // Buffer stays busy through the strobe cycle and frees on the following one.
  assign rx_release_s   = (state_r == ST_ISSUE) & (last_grant_r == GRANT_RX);

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered bus outputs and last-owner tracking
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      tr_in_r      <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      data_r       <= {DATA_W{1'b0}};
      last_grant_r <= GRANT_SNAP;
    end else begin
      tr_in_r <= grant_rx_s | grant_snap_s;
      if (grant_rx_s) begin
        addr_r       <= rx_addr_r;
        data_r       <= rx_data_r;
        last_grant_r <= GRANT_RX;
      end else if (grant_snap_s) begin
        addr_r       <= ADDR_BASE + ADDR_W'(idx_r);
        data_r       <= shadow_r[idx_r];
        last_grant_r <= GRANT_SNAP;
      end
    end
  end

  // Dump control: busy flag, word index, done pulse, mask copy, overrun count
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      snap_busy_r <= 1'b0;
      snap_done_r <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
      mask_r      <= {NUM_REGS{1'b0}};
      overrun_r   <= 8'd0;
    end else begin
      snap_done_r <= last_consume_s;
      if (capture_s) begin
        snap_busy_r <= 1'b1;
        idx_r       <= {IDX_W{1'b0}};
        mask_r      <= SNAP_MASK;
      end else if (last_consume_s) begin
        snap_busy_r <= 1'b0;
        idx_r       <= {IDX_W{1'b0}};
      end else if (consume_s) begin
        idx_r <= idx_r + IDX_W'(1'b1);
      end
      if (drop_s) begin
        overrun_r <= sat_inc8(overrun_r);
      end
    end
  end

  // Shadow data bank; contents are don't-care until the first capture
  always_ff @(posedge CLK) begin
    if (capture_s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_r[i] <= SNAP_DATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // Single-entry receiver holding buffer
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rx_full_r <= 1'b0;
      rx_prio_r <= 1'b0;
      rx_addr_r <= {ADDR_W{1'b0}};
      rx_data_r <= {DATA_W{1'b0}};
    end else if (rx_accept_s) begin
      rx_full_r <= 1'b1;
      rx_prio_r <= Reveiver_priority;
      rx_addr_r <= Reveiver_ADDR;
      rx_data_r <= Reveiver_DATA;
    end else if (rx_release_s) begin
      rx_full_r <= 1'b0;
    end
  end

  assign TR_IN               = tr_in_r;
  assign ADDR_IN             = addr_r;
  assign DATA_IN             = data_r;
  assign SNAP_BUSY           = snap_busy_r;
  assign SNAP_DONE           = snap_done_r;
  assign OVERRUN_CNT         = overrun_r;
  assign Reveiver_TR_IN_BUSY = rx_full_r;

endmodule

// File: tb/tb_device_data_collector_n.sv
// -----------------------------------------------------------------------------
// tb_device_data_collector_n
// Directed, table-driven bench for device_data_collector_n (NUM_REGS=21,
// ADDR_BASE=300). A negedge monitor records every write strobe; dumps from a
// vector table are checked against hand-computed counts/addresses/durations,
// followed by hand-written receiver, back-pressure, overrun, reset and
// capture-on-last-word sequences.
// -----------------------------------------------------------------------------
module tb_device_data_collector_n;

  localparam int NR = 21;
  localparam int DW = 32;
  localparam int AW = 16;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic             SNAP_TRIG;
  logic [NR*DW-1:0] SNAP_DATA;
  logic [NR-1:0]    SNAP_MASK;
  logic             Reveiver_priority;
  logic [AW-1:0]    Reveiver_ADDR;
  logic [DW-1:0]    Reveiver_DATA;
  logic             Reveiver_TR;
  logic             Reveiver_TR_IN_BUSY;
  logic             TR_IN;
  logic [AW-1:0]    ADDR_IN;
  logic [DW-1:0]    DATA_IN;
  logic             TR_IN_BUSY;
  logic             SNAP_BUSY;
  logic             SNAP_DONE;
  logic [7:0]       OVERRUN_CNT;

  always #5 CLK = ~CLK;

  device_data_collector_n #(
    .NUM_REGS  (NR),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .ADDR_BASE (16'd300)
  ) dut (
    .CLK                 (CLK),
    .RESET_N             (RESET_N),
    .SNAP_TRIG           (SNAP_TRIG),
    .SNAP_DATA           (SNAP_DATA),
    .SNAP_MASK           (SNAP_MASK),
    .Reveiver_priority   (Reveiver_priority),
    .Reveiver_ADDR       (Reveiver_ADDR),
    .Reveiver_DATA       (Reveiver_DATA),
    .Reveiver_TR         (Reveiver_TR),
    .Reveiver_TR_IN_BUSY (Reveiver_TR_IN_BUSY),
    .TR_IN               (TR_IN),
    .ADDR_IN             (ADDR_IN),
    .DATA_IN             (DATA_IN),
    .TR_IN_BUSY          (TR_IN_BUSY),
    .SNAP_BUSY           (SNAP_BUSY),
    .SNAP_DONE           (SNAP_DONE),
    .OVERRUN_CNT         (OVERRUN_CNT)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Strobe monitor (sampled on the inactive edge)
  logic [AW-1:0] st_addr [$];
  logic [DW-1:0] st_data [$];
  int   busy_cnt   = 0;
  int   done_cnt   = 0;
  int   b2b_cnt    = 0;
  int   busy_strb  = 0;
  logic prev_tr    = 1'b0;

  always @(negedge CLK) begin
    if (TR_IN) begin
      st_addr.push_back(ADDR_IN);
      st_data.push_back(DATA_IN);
    end
    if (TR_IN && prev_tr)     b2b_cnt   <= b2b_cnt + 1;
    if (TR_IN && TR_IN_BUSY)  busy_strb <= busy_strb + 1;
    if (SNAP_BUSY)            busy_cnt  <= busy_cnt + 1;
    if (SNAP_DONE)            done_cnt  <= done_cnt + 1;
    prev_tr <= TR_IN;
  end

  typedef struct {
    logic [NR-1:0] mask;
    int            base;
    int            exp_cnt;
    int            exp_last_addr;
    int            exp_last_data;
    int            exp_busy;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_data(input int base);
    for (int i = 0; i < NR; i++) SNAP_DATA[i*DW +: DW] = 32'(base + i);
  endtask

  task automatic trig(input int hi, input int lo);
    SNAP_TRIG = 1'b1;
    repeat (hi) tick();
    SNAP_TRIG = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic wait_strobes(input int n);
    for (int k = 0; k < 500 && st_addr.size() < n; k++) tick();
    check("wait_strobes", 64'(st_addr.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 500 && done_cnt < target; k++) tick();
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tr_in"},   64'(TR_IN), 64'd0);
    check({tag, "_addr"},    64'(ADDR_IN), 64'd0);
    check({tag, "_data"},    64'(DATA_IN), 64'd0);
    check({tag, "_busy"},    64'(SNAP_BUSY), 64'd0);
    check({tag, "_done"},    64'(SNAP_DONE), 64'd0);
    check({tag, "_overrun"}, 64'(OVERRUN_CNT), 64'd0);
    check({tag, "_rx_busy"}, 64'(Reveiver_TR_IN_BUSY), 64'd0);
  endtask

  // Expected snapshot stream for a mask: ascending index, addr 300+i, data base+i
  task automatic check_stream(input int s0, input logic [NR-1:0] mask, input int base);
    int j = s0;
    for (int i = 0; i < NR; i++) begin
      if (mask[i]) begin
        if (j < st_addr.size()) begin
          check("word_addr", 64'(st_addr[j]), 64'(300 + i));
          check("word_data", 64'(st_data[j]), 64'(base + i));
        end
        j++;
      end
    end
  endtask

  task automatic run_dump(input vec_t v);
    int s0, d0, b0, n;
    SNAP_MASK = v.mask;
    set_data(v.base);
    s0 = st_addr.size();
    d0 = done_cnt;
    b0 = busy_cnt;
    trig(3, 1);
    wait_done(d0 + 1);
    n = st_addr.size() - s0;
    check("dump_strobes", 64'(n), 64'(v.exp_cnt));
    check("dump_busy_cycles", 64'(busy_cnt - b0), 64'(v.exp_busy));
    check("dump_done_pulses", 64'(done_cnt - d0), 64'd1);
    check_stream(s0, v.mask, v.base);
    if (n > 0) begin
      check("dump_last_addr", 64'(st_addr[st_addr.size()-1]), 64'(v.exp_last_addr));
      check("dump_last_data", 64'(st_data[st_data.size()-1]), 64'(v.exp_last_data));
    end
  endtask

  task automatic rx_inject(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic p);
    for (int k = 0; k < 100 && Reveiver_TR_IN_BUSY; k++) tick();
    Reveiver_TR       = 1'b1;
    Reveiver_ADDR     = a;
    Reveiver_DATA     = d;
    Reveiver_priority = p;
    tick();
    check("rx_busy_after_accept", 64'(Reveiver_TR_IN_BUSY), 64'd1);
    // strobe while full must be dropped
    Reveiver_ADDR     = 16'h0077;
    Reveiver_DATA     = 32'hDEAD0077;
    Reveiver_priority = 1'b1;
    tick();
    Reveiver_TR       = 1'b0;
    Reveiver_priority = 1'b0;
  endtask

  function automatic int find_addr(input int from, input logic [AW-1:0] a);
    for (int i = from; i < st_addr.size(); i++) if (st_addr[i] == a) return i;
    return -1;
  endfunction

  // Two rx writes during a dump; expected gap between them in the stream
  task automatic rx_pair(input logic second_prio, input int exp_gap);
    int s0, d0, p1, p2, junk;
    SNAP_MASK = {NR{1'b1}};
    set_data(100);
    s0 = st_addr.size();
    d0 = done_cnt;
    trig(3, 1);
    wait_strobes(s0 + 3);
    rx_inject(16'h0010, 32'hABCD0001, 1'b0);
    rx_inject(16'h0020, 32'hABCD0002, second_prio);
    wait_done(d0 + 1);
    p1 = find_addr(s0, 16'h0010);
    p2 = find_addr(s0, 16'h0020);
    junk = find_addr(s0, 16'h0077);
    check("rx_total_strobes", 64'(st_addr.size() - s0), 64'd23);
    check("rx_gap", 64'(p2 - p1), 64'(exp_gap));
    check("rx_ignored_absent", 64'(junk), 64'hFFFF_FFFF_FFFF_FFFF);
    if (p1 > s0) begin
      check("rx1_data", 64'(st_data[p1]), 64'hABCD0001);
      check("rx1_after_snap_word", 64'(st_addr[p1-1] >= 16'd300), 64'd1);
    end
    if (p2 > p1 && p2 >= 0) check("rx2_data", 64'(st_data[p2]), 64'hABCD0002);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    int s0, d0, n0;

    vecs[0] = '{mask: 21'h1FFFFF, base: 100, exp_cnt: 21, exp_last_addr: 320, exp_last_data: 120, exp_busy: 61};
    vecs[1] = '{mask: 21'h100101, base: 100, exp_cnt: 3,  exp_last_addr: 320, exp_last_data: 120, exp_busy: 25};
    vecs[2] = '{mask: 21'h000000, base: 100, exp_cnt: 0,  exp_last_addr: 0,   exp_last_data: 0,   exp_busy: 21};
    vecs[3] = '{mask: 21'h100000, base: 7,   exp_cnt: 1,  exp_last_addr: 320, exp_last_data: 27,  exp_busy: 21};
    vecs[4] = '{mask: 21'h000001, base: 5,   exp_cnt: 1,  exp_last_addr: 300, exp_last_data: 5,   exp_busy: 23};

    RESET_N           = 1'b0;
    SNAP_TRIG         = 1'b0;
    SNAP_DATA         = '0;
    SNAP_MASK         = '0;
    Reveiver_priority = 1'b0;
    Reveiver_ADDR     = '0;
    Reveiver_DATA     = '0;
    Reveiver_TR       = 1'b0;
    TR_IN_BUSY        = 1'b0;

    repeat (3) tick();
    @(negedge CLK);
    check_outputs_zero("reset");
    tick();
    RESET_N = 1'b1;
    repeat (2) tick();

    // Table-driven dumps
    for (int v = 0; v < 5; v++) run_dump(vecs[v]);

    // Receiver interleave: plain second write yields to one snapshot word;
    // a prioritised second write goes straight after the first
    rx_pair(1'b0, 2);
    rx_pair(1'b1, 1);

    // Back-pressure and overruns during a stalled dump
    SNAP_MASK = {NR{1'b1}};
    set_data(100);
    s0 = st_addr.size();
    d0 = done_cnt;
    trig(3, 1);
    wait_strobes(s0 + 2);
    TR_IN_BUSY = 1'b1;
    n0 = st_addr.size();
    SNAP_MASK = '0;
    set_data(500);
    repeat (50) tick();
    check("busy_hold_no_strobe", 64'(st_addr.size()), 64'(n0));
    trig(2, 2);
    check("overrun_one", 64'(OVERRUN_CNT), 64'd1);
    repeat (300) trig(2, 2);
    check("overrun_saturate", 64'(OVERRUN_CNT), 64'd255);
    check("busy_hold_still_dumping", 64'(SNAP_BUSY), 64'd1);
    check("busy_hold_no_strobe_long", 64'(st_addr.size()), 64'(n0));
    TR_IN_BUSY = 1'b0;
    wait_done(d0 + 1);
    check("stall_total_strobes", 64'(st_addr.size() - s0), 64'd21);
    check_stream(s0, {NR{1'b1}}, 100);

    // Reset in the middle of a dump, just before word 10
    SNAP_MASK = {NR{1'b1}};
    set_data(100);
    s0 = st_addr.size();
    trig(3, 1);
    wait_strobes(s0 + 10);
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    @(negedge CLK);
    check_outputs_zero("midreset");
    n0 = st_addr.size();
    repeat (6) tick();
    check("midreset_quiet", 64'(st_addr.size()), 64'(n0));
    run_dump(vecs[0]);

    // Trigger captured in the same cycle the last word is consumed
    SNAP_MASK = '0;
    s0 = st_addr.size();
    d0 = done_cnt;
    SNAP_TRIG = 1'b1;
    for (int k = 0; k < 10 && !SNAP_BUSY; k++) tick();
    SNAP_TRIG = 1'b0;
    repeat (18) tick();
    SNAP_MASK = 21'h000001;
    set_data(5);
    SNAP_TRIG = 1'b1;
    repeat (3) tick();
    SNAP_TRIG = 1'b0;
    check("coincide_busy", 64'(SNAP_BUSY), 64'd1);
    check("coincide_done", 64'(SNAP_DONE), 64'd1);
    check("coincide_no_overrun", 64'(OVERRUN_CNT), 64'd0);
    wait_done(d0 + 2);
    check("coincide_done_pulses", 64'(done_cnt - d0), 64'd2);
    check("coincide_strobes", 64'(st_addr.size() - s0), 64'd1);
    if (st_addr.size() > s0) begin
      check("coincide_addr", 64'(st_addr[s0]), 64'd300);
      check("coincide_data", 64'(st_data[s0]), 64'd5);
    end

    // Whole-run bus rules
    check("no_back_to_back_strobes", 64'(b2b_cnt), 64'd0);
    check("no_strobe_while_downstream_busy", 64'(busy_strb), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/device_data_collector_n.md
Name: device_data_collector_n

Overview:
Parametrised successor to the GPS/device status collector. On each rising edge of a once-per-second trigger it snapshots NUM_REGS status words into a shadow bank, then serialises them as register writes (ADDR_BASE+i) onto the shared TR_IN write bus. It also arbitrates that bus with a pass-through Reveiver write channel, using its priority flag. It sits between the GPS/timing front end, the receiver command path and the register-file write port.

Parameters:
NUM_REGS, 21, number of snapshot words (1..64)
ADDR_BASE, 16'd300, address of snapshot word 0
DATA_W, 32, data width of every word
ADDR_W, 16, address width

Ports:
CLK  in  1  single system clock (TR_CLK domain folded into CLK)
RESET_N  in  1  synchronous, active-low reset
SNAP_TRIG  in  1  1PPS trigger, asynchronous; synchronised internally
SNAP_DATA  in  NUM_REGS*DATA_W  flat status bus; word i = bits [i*DATA_W +: DATA_W]
SNAP_MASK  in  NUM_REGS  1 = word i is emitted, 0 = skipped
Reveiver_priority  in  1  1 = receiver write beats a pending snapshot word
Reveiver_ADDR  in  ADDR_W  receiver write address
Reveiver_DATA  in  DATA_W  receiver write data
Reveiver_TR  in  1  one-cycle receiver write strobe
Reveiver_TR_IN_BUSY  out  1  receiver holding buffer full
TR_IN  out  1  one-cycle write strobe to register file
ADDR_IN  out  ADDR_W  write address, valid while TR_IN=1
DATA_IN  out  DATA_W  write data, valid while TR_IN=1
TR_IN_BUSY  in  1  downstream cannot accept a strobe
SNAP_BUSY  out  1  snapshot dump in progress
SNAP_DONE  out  1  one-cycle pulse after the last word of a dump
OVERRUN_CNT  out  8  saturating count of triggers dropped during a dump

Behaviour:
- Reset: all outputs 0, FSM=IDLE, rx buffer empty, idx=0, last_grant=SNAP, sync FFs 0.
- Trigger: 2-FF synchroniser plus edge detect. The capture cycle is the 3rd CLK edge after SNAP_TRIG rises. On capture with SNAP_BUSY=0: copy SNAP_DATA and SNAP_MASK to the shadow bank, set SNAP_BUSY, set idx=0. On capture with SNAP_BUSY=1: the shadow bank is untouched and OVERRUN_CNT increments, saturating at 255.
- Rx buffer: one entry holding addr, data and priority. Reveiver_TR is accepted only when Reveiver_TR_IN_BUSY=0. Reveiver_TR_IN_BUSY=1 from the cycle after acceptance until the cycle after the entry is issued. A strobe while busy is ignored.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE, TR_IN_BUSY=1: stay.
  - IDLE, TR_IN_BUSY=0: arbitrate as below.
  - ISSUE: TR_IN=1 for exactly one cycle, then GAP.
  - GAP: one cycle, then IDLE. Downstream busy therefore has one cycle to assert before the next strobe.
- Arbitration in IDLE, when TR_IN_BUSY=0:
  - Rx is granted if the rx buffer is full and at least one holds: stored priority=1, last_grant=SNAP, or SNAP_BUSY=0.
  - Otherwise, if SNAP_BUSY=1 and shadow mask[idx]=1: grant the snapshot word, ADDR_IN=ADDR_BASE+idx, DATA_IN=shadow[idx].
  - If SNAP_BUSY=1 and mask[idx]=0: no issue; idx advances, costing 1 cycle.
  - Grant sets last_grant. With no priority this gives fair alternation.
- Index: idx advances after each snapshot issue or skip. When idx=NUM_REGS-1 is consumed: clear SNAP_BUSY, pulse SNAP_DONE, idx=0.
- Empty mask: the dump completes in NUM_REGS cycles with no TR_IN, and SNAP_DONE still pulses.
- Address arithmetic: ADDR_BASE+idx, ADDR_W bits, wraps modulo 2^ADDR_W.
- Simultaneous events:
  - Capture and the final word in the same cycle: the final word completes first, then the capture is accepted (no overrun).
  - Rx acceptance and rx issue in the same cycle cannot occur (buffer is busy).
- Reset mid-dump: dump aborted, shadow contents don't-care, no TR_IN in the cycle after reset.
- TR_IN is never asserted in consecutive cycles.

Decomposition:
- Package dc_pkg: FSM state encoding, GRANT_RX/GRANT_SNAP constants, OVERRUN_MAX.
- Sub-module sync_edge_detect (2-FF synchroniser + rising-edge pulse), reusable for other 1PPS inputs.

Test Plan:
- NUM_REGS=21, mask all 1, SNAP_DATA word i=i+100, one trigger -> 21 strobes, ADDR_IN 300..320, DATA_IN 100..120, ≥2 cycles apart, then SNAP_DONE.
- Mask = only bits 0,8,20 -> exactly 3 strobes at 300,308,320, and SNAP_DONE pulses.
- Dump in progress; Reveiver_TR with priority=0, addr 0x0010 -> rx write interleaved after the next snapshot word; with priority=1 it is issued at the next IDLE before any snapshot word.
- TR_IN_BUSY held 1 for 50 cycles mid-dump -> no strobe while high; dump resumes at the same idx, with no word lost or duplicated.
- Second trigger during a dump -> OVERRUN_CNT=1, original data emitted intact; 300 overrun triggers -> OVERRUN_CNT=255.
- RESET_N low for 1 cycle at word 10 -> all outputs 0; the next trigger restarts at address 300.
